vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-port VRAM arbiter sharing the 2048×32 video RAM between the scanline graphics fetcher (`gfx`) and the CPU bus. The graphics side has fixed priority and zero-wait, pipelined reads. The CPU side uses a valid/ready memory handshake and is serviced in idle RAM cycles. A programmable starvation limit lets the CPU force one slot when the fetcher monopolises the RAM. The block sits between `gfx`/CPU interconnect and the `sprom`/RAM instance.

## Interface

Parameters:
- `AW`, 11, VRAM word-address width
- `DW`, 32, VRAM data width
- `STARVE_LIMIT`, 0, consecutive CPU-blocked cycles before a forced CPU slot; 0 disables forcing

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `gfx_req_i`  in  1  graphics read request this cycle
- `gfx_addr_i`  in  AW  graphics word address
- `gfx_valid_o`  out  1  `gfx_rdata_o` valid (read issued previous cycle)
- `gfx_rdata_o`  out  DW  graphics read data
- `gfx_denied_o`  out  1  pulse: `gfx_req_i` this cycle was not serviced
- `cpu_valid_i`  in  1  CPU request, held until `cpu_ready_o`
- `cpu_wstrb_i`  in  4  byte write enables; 0 = read
- `cpu_addr_i`  in  AW  CPU word address
- `cpu_wdata_i`  in  DW  CPU write data
- `cpu_ready_o`  out  1  one-cycle completion pulse
- `cpu_rdata_o`  out  DW  CPU read data, valid with `cpu_ready_o`
- `ram_addr_o`  out  AW  RAM address
- `ram_we_o`  out  4  RAM byte write enables
- `ram_wdata_o`  out  DW  RAM write data
- `ram_rdata_i`  in  DW  RAM read data, one-cycle latency after address

## Operation

- The RAM has one port: exactly one requester owns it per cycle. The owner is decided combinationally from `gfx_req_i`, the CPU FSM state, and the starvation counter.
- Graphics grant is the default. If `gfx_req_i` is high and no force is pending:
  - `ram_addr_o = gfx_addr_i`, `ram_we_o = 0`.
  - Next cycle `gfx_valid_o = 1` and `gfx_rdata_o = ram_rdata_i` (pass-through).
- CPU FSM states are IDLE, WAIT and ACK.
  - IDLE → WAIT: when `cpu_valid_i` is high and the CPU owns the RAM. The CPU owns the RAM when `gfx_req_i` is low, or when a force is pending. In that cycle `ram_addr_o = cpu_addr_i`, `ram_we_o = cpu_wstrb_i` and `ram_wdata_o = cpu_wdata_i`.
  - WAIT → ACK, unconditionally: register `cpu_rdata_o <= ram_rdata_i`. This is don't-care for writes.
  - ACK → IDLE, unconditionally: `cpu_ready_o = 1`. No new CPU issue happens in ACK. The RAM remains available to gfx in WAIT and ACK.
- Starvation counter `blk_cnt`, width `$clog2(STARVE_LIMIT+1)`:
  - Increments while FSM = IDLE, `cpu_valid_i` is high and gfx holds the grant.
  - Clears on CPU issue or when `cpu_valid_i` is low.
  - Force pending = `STARVE_LIMIT != 0 && blk_cnt == STARVE_LIMIT`.
  - On a forced cycle with `gfx_req_i` high, `gfx_denied_o` pulses and `gfx_valid_o` is 0 the following cycle.
- `ram_we_o` is nonzero only in a CPU issue cycle. When no one owns the RAM, outputs are `ram_addr_o = 0` and `ram_we_o = 0`.

## Timing

- Graphics read latency: `gfx_req_i` cycle N → `gfx_valid_o` cycle N+1. Throughput is one read per cycle.
- CPU latency: issue cycle N → `cpu_ready_o` cycle N+2, for both read and write. Minimum time from `cpu_valid_i` rising to ready is 2 cycles.
- A write is committed to RAM at the issue-cycle clock edge. A gfx read of the same address issued the next cycle returns the new data.
- Worst-case CPU wait with forcing enabled: `STARVE_LIMIT` + 2 cycles from `cpu_valid_i` to ready.
- Reset: FSM = IDLE, `blk_cnt = 0`. `gfx_valid_o`, `gfx_denied_o` and `cpu_ready_o` are 0. `cpu_rdata_o = 0`. `ram_we_o = 0`.
- Reset in WAIT or ACK aborts the transaction with no `cpu_ready_o` pulse. A write already issued remains in RAM.
- `cpu_valid_i` dropped before ready (protocol violation): the FSM still completes to ACK and pulses `cpu_ready_o`.
- `gfx_req_i` and force in the same cycle: the CPU wins. A force is consumed by exactly one issue.

## Structure

- Shared package `vram_pkg`:
  - FSM state enum (IDLE, WAIT, ACK).
  - Default `AW`/`DW` constants, reused by `gfx` and the RAM instance.
- Single module. The ownership mux and FSM are small enough that no sub-module is warranted.

## Test plan

- CPU write then read, gfx idle: write `0xDEADBEEF` @ `0x123` with `wstrb = 0xF`, then read `0x123` → `cpu_ready_o` 2 cycles after each issue; `cpu_rdata_o = 0xDEADBEEF`.
- Byte strobe: preload `0x11223344` @ `0x010`, write `0xAABBCCDD` with `wstrb = 0x2` → readback `0x1122CC44`.
- Gfx burst of 640 consecutive reqs from `0x000` with `STARVE_LIMIT = 0`, CPU read pending → `gfx_valid_o` every cycle with data of addr-1. CPU issues on the first cycle after the burst and gets ready 2 cycles later. `gfx_denied_o` never asserts.
- `STARVE_LIMIT = 8`, continuous `gfx_req_i`, CPU read at `0x7FF` → CPU issues on the 9th blocked cycle; `gfx_denied_o` pulses once; `gfx_valid_o` low exactly one cycle; ready at issue+2.
- Write `0x5A5A5A5A` @ `0x040` immediately followed by gfx read @ `0x040` → `gfx_rdata_o = 0x5A5A5A5A`.
- Assert `rst` during WAIT of a CPU read → no `cpu_ready_o`; all outputs at reset values next cycle; a new request completes normally.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM definitions: default geometry, CPU-side FSM states and the
// starvation-counter width helper.
package vram_pkg;

    localparam int unsigned VramAw = 11;
    localparam int unsigned VramDw = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } cpu_state_e;

    // A limit of 0 disables forcing but still needs a legal 1-bit counter.
    function automatic int unsigned starve_cnt_w(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the graphics, CPU and RAM-side signals around the VRAM arbiter.
interface vram_arbiter_if #(
    parameter int unsigned AW = vram_pkg::VramAw,
    parameter int unsigned DW = vram_pkg::VramDw
);
    logic          gfx_req_i;
    logic [AW-1:0] gfx_addr_i;
    logic          gfx_valid_o;
    logic [DW-1:0] gfx_rdata_o;
    logic          gfx_denied_o;

    logic          cpu_valid_i;
    logic [3:0]    cpu_wstrb_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_wdata_i;
    logic          cpu_ready_o;
    logic [DW-1:0] cpu_rdata_o;

    logic [AW-1:0] ram_addr_o;
    logic [3:0]    ram_we_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    // Arbiter side.
    modport slave (
        input  gfx_req_i, gfx_addr_i, cpu_valid_i, cpu_wstrb_i, cpu_addr_i, cpu_wdata_i,
        input  ram_rdata_i,
        output gfx_valid_o, gfx_rdata_o, gfx_denied_o, cpu_ready_o, cpu_rdata_o,
        output ram_addr_o, ram_we_o, ram_wdata_o
    );

    // Requesters and RAM side.
    modport master (
        output gfx_req_i, gfx_addr_i, cpu_valid_i, cpu_wstrb_i, cpu_addr_i, cpu_wdata_i,
        output ram_rdata_i,
        input  gfx_valid_o, gfx_rdata_o, gfx_denied_o, cpu_ready_o, cpu_rdata_o,
        input  ram_addr_o, ram_we_o, ram_wdata_o
    );

endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: fixed-priority pipelined graphics reads, CPU accesses
// in idle cycles, with an optional starvation limit that forces one CPU slot.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned AW           = VramAw,
    parameter int unsigned DW           = VramDw,
    parameter int unsigned STARVE_LIMIT = 0
) (
    input logic           clk,
    input logic           rst,
    vram_arbiter_if.slave bus
);

    localparam int unsigned     CntW  = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    cpu_state_e    state_q, state_d;
    logic [CntW-1:0] blk_cnt_q, blk_cnt_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          gfx_valid_q;

    logic force_slot;
    logic cpu_take;
    logic gfx_grant;

    always_comb begin
        force_slot = (STARVE_LIMIT != 0) && (blk_cnt_q == Limit);
        cpu_take   = (state_q == StIdle) && bus.cpu_valid_i && (!bus.gfx_req_i || force_slot);
        gfx_grant  = bus.gfx_req_i && !cpu_take;
    end

    always_comb begin
        state_d     = state_q;
        cpu_rdata_d = cpu_rdata_q;
        case (state_q)
            StIdle: if (cpu_take) state_d = StWait;
            StWait: begin
                state_d     = StAck;
                cpu_rdata_d = bus.ram_rdata_i;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Counts only cycles in which a pending CPU request lost to graphics.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (cpu_take || !bus.cpu_valid_i) begin
            blk_cnt_d = '0;
        end else if (state_q == StIdle && gfx_grant) begin
            blk_cnt_d = blk_cnt_q + CntW'(1);
        end
    end

    always_comb begin
        bus.ram_addr_o  = '0;
        bus.ram_we_o    = '0;
        bus.ram_wdata_o = '0;
        if (cpu_take) begin
            bus.ram_addr_o  = bus.cpu_addr_i;
            bus.ram_we_o    = bus.cpu_wstrb_i;
            bus.ram_wdata_o = bus.cpu_wdata_i;
        end else if (gfx_grant) begin
            bus.ram_addr_o = bus.gfx_addr_i;
        end
    end

    always_comb begin
        bus.gfx_valid_o  = gfx_valid_q;
        bus.gfx_rdata_o  = bus.ram_rdata_i;
        bus.gfx_denied_o = bus.gfx_req_i && cpu_take;
        bus.cpu_ready_o  = (state_q == StAck);
        bus.cpu_rdata_o  = cpu_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            blk_cnt_q   <= '0;
            cpu_rdata_q <= '0;
            gfx_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            gfx_valid_q <= gfx_grant;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench: two arbiters (forcing off / limit 8) each with a behavioural
// 2048x32 byte-writable RAM; drivers queue expectations, monitors check them.
module tb_vram_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    int          tgt;
    logic        gfx_req;
    logic [10:0] gfx_addr;
    logic        cpu_valid;
    logic [3:0]  cpu_wstrb;
    logic [10:0] cpu_addr;
    logic [31:0] cpu_wdata;

    exp_t cq0[$], gq0[$], cq8[$], gq8[$];
    int   den0 = 0, den8 = 0, den_cyc8 = -1;

    logic [31:0] mem0 [2048];
    logic [31:0] mem8 [2048];
    bit          wr0 [2048];
    bit          wr8 [2048];

    vram_arbiter_if #(.AW(11), .DW(32)) bus0 ();
    vram_arbiter_if #(.AW(11), .DW(32)) bus8 ();

    vram_arbiter #(.AW(11), .DW(32), .STARVE_LIMIT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    vram_arbiter #(.AW(11), .DW(32), .STARVE_LIMIT(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus0.gfx_req_i   = (tgt == 0) && gfx_req;
    assign bus0.gfx_addr_i  = gfx_addr;
    assign bus0.cpu_valid_i = (tgt == 0) && cpu_valid;
    assign bus0.cpu_wstrb_i = cpu_wstrb;
    assign bus0.cpu_addr_i  = cpu_addr;
    assign bus0.cpu_wdata_i = cpu_wdata;
    assign bus8.gfx_req_i   = (tgt == 8) && gfx_req;
    assign bus8.gfx_addr_i  = gfx_addr;
    assign bus8.cpu_valid_i = (tgt == 8) && cpu_valid;
    assign bus8.cpu_wstrb_i = cpu_wstrb;
    assign bus8.cpu_addr_i  = cpu_addr;
    assign bus8.cpu_wdata_i = cpu_wdata;

    // Contents of a never-written word.
    function automatic logic [31:0] pat(input logic [10:0] a);
        return 32'hC0DE_0000 | {21'd0, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur0, cur8;
        cur0 = wr0[bus0.ram_addr_o] ? mem0[bus0.ram_addr_o] : pat(bus0.ram_addr_o);
        cur8 = wr8[bus8.ram_addr_o] ? mem8[bus8.ram_addr_o] : pat(bus8.ram_addr_o);
        if (bus0.ram_we_o != 4'd0) begin
            mem0[bus0.ram_addr_o] <= merge(cur0, bus0.ram_wdata_o, bus0.ram_we_o);
            wr0[bus0.ram_addr_o]  <= 1'b1;
        end
        if (bus8.ram_we_o != 4'd0) begin
            mem8[bus8.ram_addr_o] <= merge(cur8, bus8.ram_wdata_o, bus8.ram_we_o);
            wr8[bus8.ram_addr_o]  <= 1'b1;
        end
        bus0.ram_rdata_i <= cur0;
        bus8.ram_rdata_i <= cur8;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus0.cpu_ready_o === 1'b1) begin
            if (cq0.size() == 0) fail_now("cpu0_unexpected_ready");
            else begin
                e = cq0.pop_front();
                check("cpu0_ready_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk) check("cpu0_rdata", 64'(bus0.cpu_rdata_o), 64'(e.data));
            end
        end
        if (bus0.gfx_valid_o === 1'b1) begin
            if (gq0.size() == 0) fail_now("gfx0_unexpected_valid");
            else begin
                e = gq0.pop_front();
                check("gfx0_valid_cycle", 64'(cyc), 64'(e.cyc));
                check("gfx0_rdata", 64'(bus0.gfx_rdata_o), 64'(e.data));
            end
        end
        if (bus8.cpu_ready_o === 1'b1) begin
            if (cq8.size() == 0) fail_now("cpu8_unexpected_ready");
            else begin
                e = cq8.pop_front();
                check("cpu8_ready_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk) check("cpu8_rdata", 64'(bus8.cpu_rdata_o), 64'(e.data));
            end
        end
        if (bus8.gfx_valid_o === 1'b1) begin
            if (gq8.size() == 0) fail_now("gfx8_unexpected_valid");
            else begin
                e = gq8.pop_front();
                check("gfx8_valid_cycle", 64'(cyc), 64'(e.cyc));
                check("gfx8_rdata", 64'(bus8.gfx_rdata_o), 64'(e.data));
            end
        end
        if (bus0.gfx_denied_o === 1'b1) den0++;
        if (bus8.gfx_denied_o === 1'b1) begin
            den8++;
            den_cyc8 = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gfx_push(input int sel, input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        e.chk  = 1'b1;
        if (sel == 0) gq0.push_back(e);
        else gq8.push_back(e);
    endtask

    // Issues one CPU access on bus `sel`; delay is the hand-derived valid-to-ready count.
    task automatic cpu_op(input int sel, input logic [3:0] we, input logic [10:0] a,
                          input logic [31:0] wd, input logic [31:0] exp, input int delay);
        exp_t e;
        bit   seen;
        e.data = exp;
        e.cyc  = cyc + delay;
        e.chk  = (we == 4'd0);
        if (sel == 0) cq0.push_back(e);
        else cq8.push_back(e);
        cpu_valid = 1'b1;
        cpu_wstrb = we;
        cpu_addr  = a;
        cpu_wdata = wd;
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ((sel == 0) ? bus0.cpu_ready_o : bus8.cpu_ready_o) begin
                seen = 1'b1;
                break;
            end
        end
        step();
        cpu_valid = 1'b0;
        cpu_wstrb = 4'd0;
        if (!seen) fail_now("cpu_ready_timeout");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_gfx_valid0"}, 64'(bus0.gfx_valid_o), 64'd0);
        check({tag, "_gfx_denied0"}, 64'(bus0.gfx_denied_o), 64'd0);
        check({tag, "_cpu_ready0"}, 64'(bus0.cpu_ready_o), 64'd0);
        check({tag, "_cpu_rdata0"}, 64'(bus0.cpu_rdata_o), 64'd0);
        check({tag, "_ram_we0"}, 64'(bus0.ram_we_o), 64'd0);
        check({tag, "_gfx_valid8"}, 64'(bus8.gfx_valid_o), 64'd0);
        check({tag, "_cpu_ready8"}, 64'(bus8.cpu_ready_o), 64'd0);
        check({tag, "_cpu_rdata8"}, 64'(bus8.cpu_rdata_o), 64'd0);
        check({tag, "_ram_we8"}, 64'(bus8.ram_we_o), 64'd0);
    endtask

    initial begin
        int s8;
        rst       = 1'b1;
        tgt       = 0;
        gfx_req   = 1'b0;
        gfx_addr  = '0;
        cpu_valid = 1'b0;
        cpu_wstrb = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");
        step();

        // 640-read burst with a CPU read pending from its first cycle.
        fork
            begin
                for (int i = 0; i < 640; i++) begin
                    gfx_req  = 1'b1;
                    gfx_addr = 11'(i);
                    gfx_push(0, pat(11'(i)), cyc + 1);
                    step();
                end
                gfx_req = 1'b0;
            end
            cpu_op(0, 4'h0, 11'h7FF, 32'd0, pat(11'h7FF), 642);
        join

        cpu_op(0, 4'hF, 11'h123, 32'hDEAD_BEEF, 32'd0, 2);
        cpu_op(0, 4'h0, 11'h123, 32'd0, 32'hDEAD_BEEF, 2);
        cpu_op(0, 4'hF, 11'h010, 32'h1122_3344, 32'd0, 2);
        cpu_op(0, 4'h2, 11'h010, 32'hAABB_CCDD, 32'd0, 2);
        cpu_op(0, 4'h0, 11'h010, 32'd0, 32'h1122_CC44, 2);

        // Write then a graphics read of the same word on the very next cycle.
        fork
            cpu_op(0, 4'hF, 11'h040, 32'h5A5A_5A5A, 32'd0, 2);
            begin
                step();
                gfx_req  = 1'b1;
                gfx_addr = 11'h040;
                gfx_push(0, 32'h5A5A_5A5A, cyc + 1);
                step();
                gfx_req = 1'b0;
            end
        join

        // Reset while the CPU read sits in WAIT: no ready, then a clean retry.
        cpu_valid = 1'b1;
        cpu_wstrb = 4'h0;
        cpu_addr  = 11'h123;
        step();
        rst = 1'b1;
        step();
        rst       = 1'b0;
        cpu_valid = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        step();
        cpu_op(0, 4'h0, 11'h123, 32'd0, 32'hDEAD_BEEF, 2);

        // Starvation forcing with limit 8 under continuous graphics requests.
        tgt = 8;
        s8  = cyc;
        fork
            begin
                for (int k = 0; k < 14; k++) begin
                    gfx_req  = 1'b1;
                    gfx_addr = 11'(k);
                    if (k != 8) gfx_push(8, pat(11'(k)), cyc + 1);
                    step();
                end
                gfx_req = 1'b0;
            end
            cpu_op(8, 4'h0, 11'h7FF, 32'd0, pat(11'h7FF), 10);
        join

        repeat (4) step();
        check("cpu0_queue_drained", 64'(cq0.size()), 64'd0);
        check("gfx0_queue_drained", 64'(gq0.size()), 64'd0);
        check("cpu8_queue_drained", 64'(cq8.size()), 64'd0);
        check("gfx8_queue_drained", 64'(gq8.size()), 64'd0);
        check("gfx0_denied_count", 64'(den0), 64'd0);
        check("gfx8_denied_count", 64'(den8), 64'd1);
        check("gfx8_denied_cycle", 64'(den_cyc8), 64'(s8 + 8));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
